// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and scan FSM state type.
// Segment order is {a,b,c,d,e,f,g}: bit6 = a (top), clockwise, bit0 = g (middle).
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h1F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // A dark digit reads back as F; anything that is not an exact glyph reads back as E.
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  // Per-slot capture state: waiting for a stable strobed digit, or already captured it.
  typedef enum logic {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Inverse 7-segment decoder: maps an exact segment pattern back to its BCD digit.
// Only exact glyphs are accepted; partial or corrupted patterns are flagged.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);

  // Exact-match lookup; blank is a legal pattern, everything else unknown is an error.
  always_comb begin
    bcd = BCD_ERR;
    err = 1'b1;
    case (seg)
      SEG_0:     begin bcd = 4'd0;      err = 1'b0; end
      SEG_1:     begin bcd = 4'd1;      err = 1'b0; end
      SEG_2:     begin bcd = 4'd2;      err = 1'b0; end
      SEG_3:     begin bcd = 4'd3;      err = 1'b0; end
      SEG_4:     begin bcd = 4'd4;      err = 1'b0; end
      SEG_5:     begin bcd = 4'd5;      err = 1'b0; end
      SEG_6:     begin bcd = 4'd6;      err = 1'b0; end
      SEG_7:     begin bcd = 4'd7;      err = 1'b0; end
      SEG_8:     begin bcd = 4'd8;      err = 1'b0; end
      SEG_9:     begin bcd = 4'd9;      err = 1'b0; end
      SEG_BLANK: begin bcd = BCD_BLANK; err = 1'b0; end
      default:   begin bcd = BCD_ERR;   err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Receive side of a multiplexed 7-segment bus: synchronizes the pins, waits for each
// strobed digit to settle, decodes it back to BCD and assembles complete frames
// presented on a valid/ready output.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter bit SEG_ACT_LOW   = 1'b0,
  parameter bit DIG_ACT_LOW   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [4*NUM_DIGITS-1:0] frame_bcd,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int S_W   = 7 + NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  // Synchronizer stages and polarity-corrected sample
  logic [6:0]            seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0] dig_s1, dig_s2;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] dig;
  logic [S_W-1:0]        s, prev;
  logic                  same;
  logic                  dig_onehot;
  logic [IDX_W-1:0]      idx;

  // Capture FSM
  scan_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             capture;

  // Decoder outputs
  logic [3:0] dec_bcd;
  logic       dec_err;

  // Pending frame being assembled
  logic [4*NUM_DIGITS-1:0] pend_bcd, next_bcd;
  logic [NUM_DIGITS-1:0]   pend_err, next_err;
  logic [NUM_DIGITS-1:0]   mask, next_mask;
  logic                    complete, out_free, load, drop, accept;

  // Convert a one-hot strobe to its position; only meaningful when the strobe is one-hot.
  function automatic logic [IDX_W-1:0] onehot2idx(input logic [NUM_DIGITS-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (oh[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Two-flop synchronizer on the asynchronous segment and strobe pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      dig_s1 <= '0;
      dig_s2 <= '0;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      dig_s1 <= dig_en;
      dig_s2 <= dig_s1;
    end
  end

  assign seg        = SEG_ACT_LOW ? ~seg_s2 : seg_s2;
  assign dig        = DIG_ACT_LOW ? ~dig_s2 : dig_s2;
  assign s          = {seg, dig};
  assign same       = (s == prev);
  assign dig_onehot = (dig != '0) && ((dig & (dig - NUM_DIGITS'(1))) == '0);
  assign idx        = onehot2idx(dig);

  // Previous corrected sample, used to detect a bus that has stopped moving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= s;
  end

  // State register and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SETTLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: count identical one-hot samples, capture once, then wait for the bus to move.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      SETTLE: begin
        if (!same || !dig_onehot) begin
          cnt_next = '0;
        end else if (cnt == CNT_MAX) begin
          capture    = 1'b1;
          cnt_next   = '0;
          state_next = HOLD;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!same) begin
          cnt_next   = '0;
          state_next = SETTLE;
        end
      end
    endcase
  end

  seg7_to_bcd u_dec (
    .seg (seg),
    .bcd (dec_bcd),
    .err (dec_err)
  );

  // Pending buffer as it would look with the current digit written in; completion looks at this view.
  always_comb begin
    next_bcd  = pend_bcd;
    next_err  = pend_err;
    next_mask = mask;
    next_bcd[4*int'(idx) +: 4] = dec_bcd;
    next_err[idx]              = dec_err;
    next_mask[idx]             = 1'b1;
  end

  assign accept   = frame_valid && frame_ready;
  assign out_free = !frame_valid || frame_ready;
  assign complete = capture && (next_mask == '1);
  assign load     = complete && out_free;
  assign drop     = complete && !out_free;

  // Pending buffer and slot mask; the mask empties whenever a frame completes, kept or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_bcd <= '0;
      pend_err <= '0;
      mask     <= '0;
    end else if (capture) begin
      pend_bcd <= next_bcd;
      pend_err <= next_err;
      mask     <= complete ? '0 : next_mask;
    end
  end

  // Output register: holds the frame until accepted; a same-edge accept and load keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_bcd   <= '0;
      frame_err   <= '0;
    end else if (load) begin
      frame_valid <= 1'b1;
      frame_bcd   <= next_bcd;
      frame_err   <= next_err;
    end else if (accept) begin
      frame_valid <= 1'b0;
    end
  end

  // One-cycle pulse when a completed frame had nowhere to go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else        overrun <= drop;
  end

endmodule
